// File: rtl/cell_ram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cell_ram_arbiter : shares the ping-pong cell RAM among display, engine, editor
// Rev 1.0
// ---------------------------------------------------------------------------
module cell_ram_arbiter #(
  parameter int P_PARAM_M = 5,
  parameter int P_PARAM_N = 5,
  parameter int WIDTH     = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               disp_req,
  input  logic [2*WIDTH-1:0] disp_addr,
  output logic               disp_rvalid,
  output logic               disp_rdata,
  input  logic               evo_req,
  input  logic               evo_we,
  input  logic [2*WIDTH-1:0] evo_addr,
  input  logic               evo_wdata,
  output logic               evo_gnt,
  output logic               evo_rvalid,
  output logic               evo_rdata,
  input  logic               evo_active,
  input  logic               edit_req,
  input  logic [2*WIDTH-1:0] edit_addr,
  input  logic               edit_wdata,
  output logic               edit_gnt,
  input  logic               swap_req,
  output logic               swap_done,
  input  logic               clear_req,
  output logic               busy,
  output logic               bank,
  output logic [2*WIDTH:0]   ram_addr,
  output logic               ram_we,
  output logic               ram_wdata,
  input  logic               ram_rdata
);

  localparam int              AW      = 2 * WIDTH;
  localparam int              CELLS   = P_PARAM_M * P_PARAM_N;
  localparam logic [AW-1:0]   CELLS_A = AW'(CELLS);
  localparam logic [AW-1:0]   LAST_A  = AW'(CELLS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_SWAP  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;
  logic          swap_pend, swap_pend_nxt;
  logic          bank_nxt, swap_done_nxt;
  logic          rr_edit_pri;
  logic          disp_rv, disp_oor_q, evo_rv, evo_oor_q;
  logic          evo_ok, edit_ok, clr_write;
  logic          disp_oor, evo_oor, edit_oor;

  assign disp_oor = (disp_addr >= CELLS_A);
  assign evo_oor  = (evo_addr  >= CELLS_A);
  assign edit_oor = (edit_addr >= CELLS_A);

  assign busy = (state != S_IDLE) || swap_pend;

  assign disp_rvalid = disp_rv;
  assign disp_rdata  = disp_rv & ~disp_oor_q & ram_rdata;
  assign evo_rvalid  = evo_rv;
  assign evo_rdata   = evo_rv & ~evo_oor_q & ram_rdata;

  // Port selection: display > clear sweep > engine/editor round-robin.
  always_comb begin
    evo_gnt   = 1'b0;
    edit_gnt  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = 1'b0;
    clr_write = 1'b0;
    evo_ok    = evo_req && (state == S_IDLE);
    edit_ok   = edit_req && !evo_active && !busy;
    if (!rst) begin
      if (disp_req) begin
        ram_addr = {bank, disp_addr};
      end else if (state == S_CLEAR) begin
        ram_addr  = {bank, clr_cnt};
        ram_we    = 1'b1;
        clr_write = 1'b1;
      end else if (evo_ok && (!edit_ok || !rr_edit_pri)) begin
        evo_gnt   = 1'b1;
        ram_addr  = {evo_we ? ~bank : bank, evo_addr};
        ram_we    = evo_we && !evo_oor;
        ram_wdata = evo_wdata;
      end else if (edit_ok) begin
        edit_gnt  = 1'b1;
        ram_addr  = {bank, edit_addr};
        ram_we    = !edit_oor;
        ram_wdata = edit_wdata;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    clr_cnt_nxt   = clr_cnt;
    swap_pend_nxt = swap_pend;
    bank_nxt      = bank;
    swap_done_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (clear_req) begin
          state_nxt     = S_CLEAR;
          clr_cnt_nxt   = '0;
          swap_pend_nxt = swap_pend | swap_req;
        end else if (swap_req || swap_pend) begin
          state_nxt     = S_SWAP;
          swap_pend_nxt = 1'b0;
        end
      end
      S_CLEAR: begin
        swap_pend_nxt = swap_pend | swap_req;
        if (clear_req) begin
          clr_cnt_nxt = '0;
        end else if (clr_write) begin
          if (clr_cnt == LAST_A) begin
            state_nxt   = S_IDLE;
            clr_cnt_nxt = '0;
          end else begin
            clr_cnt_nxt = clr_cnt + AW'(1);
          end
        end
      end
      S_SWAP: begin
        // Hold the flip until any engine read data has been delivered.
        if (!evo_rv) begin
          bank_nxt      = ~bank;
          swap_done_nxt = 1'b1;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      clr_cnt     <= '0;
      swap_pend   <= 1'b0;
      bank        <= 1'b0;
      swap_done   <= 1'b0;
      rr_edit_pri <= 1'b0;
      disp_rv     <= 1'b0;
      disp_oor_q  <= 1'b0;
      evo_rv      <= 1'b0;
      evo_oor_q   <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_cnt    <= clr_cnt_nxt;
      swap_pend  <= swap_pend_nxt;
      bank       <= bank_nxt;
      swap_done  <= swap_done_nxt;
      if (evo_gnt) begin
        rr_edit_pri <= 1'b1;
      end else if (edit_gnt) begin
        rr_edit_pri <= 1'b0;
      end
      disp_rv    <= disp_req;
      disp_oor_q <= disp_oor;
      evo_rv     <= evo_gnt && !evo_we;
      evo_oor_q  <= evo_oor;
    end
  end

endmodule
`default_nettype wire

// File: doc/cell_ram_arbiter.md
Name: cell_ram_arbiter

Overview:
- Shares the single-port cell RAM between three requesters: VGA display reader, generation engine, and user editor.
- Owns the ping-pong bank bit: the engine reads the current bank and writes the next bank; display and editor use the current bank.
- Sequences bank swaps at generation end and whole-bank clear sweeps.
- Sits between the requesters and the RAM primitive, which has 1-cycle synchronous read.

Parameters:
P_PARAM_M, 5, grid rows
P_PARAM_N, 5, grid columns
WIDTH, 12, half-width of cell address; cell address is 2*WIDTH bits

Ports:
clk  in  1  global clock
rst  in  1  synchronous active-high reset
disp_req  in  1  display read request
disp_addr  in  2*WIDTH  display cell address
disp_rvalid  out  1  disp_rdata valid
disp_rdata  out  1  cell state
evo_req  in  1  engine request
evo_we  in  1  1=write to next bank, 0=read from current bank
evo_addr  in  2*WIDTH  engine cell address
evo_wdata  in  1  engine write data
evo_gnt  out  1  engine request accepted this cycle
evo_rvalid  out  1  evo_rdata valid
evo_rdata  out  1  cell state
evo_active  in  1  high while a generation is in progress
edit_req  in  1  editor write request, current bank
edit_addr  in  2*WIDTH  editor cell address
edit_wdata  in  1  editor write data
edit_gnt  out  1  editor request accepted
swap_req  in  1  1-cycle pulse, generation finished
swap_done  out  1  1-cycle pulse when bank flips
clear_req  in  1  1-cycle pulse, clear current bank
busy  out  1  clear sweep or swap pending
bank  out  1  current bank
ram_addr  out  2*WIDTH+1  {bank bit, cell address}
ram_we  out  1  RAM write enable
ram_wdata  out  1  RAM write data
ram_rdata  in  1  RAM read data, valid cycle after address

Behaviour:
- Reset: all grants, rvalids, ram_we, swap_done and busy are 0; rdata outputs 0; bank=0; state=S_IDLE; round-robin pointer=engine; clear counter 0.
- Grants are combinational in the cycle the port drives the RAM. A requester holds req/addr/data stable until it sees gnt.
- Display has no gnt. It is served every cycle disp_req=1 and wins unconditionally.
- Priority order: display > clear sweep > engine/editor (round-robin).
- Round-robin: after a grant to one of engine/editor, the other has priority at the next contention.
- Editor is masked while evo_active=1 or busy=1.
- Engine is masked while state≠S_IDLE.
- Read latency: disp_rvalid/evo_rvalid=1 exactly one cycle after the granted read, carrying ram_rdata. Writes produce no rvalid.
- ram_addr bank bit:
  - display, editor, engine read, clear: current bank
  - engine write: ~bank
- Out-of-range address (≥P_PARAM_M*P_PARAM_N):
  - Still granted/served.
  - ram_we forced 0.
  - Read returns rdata=0 with rvalid=1.
- Cycles with no access: ram_we=0, ram_addr=0.
- FSM states:
  - S_IDLE:
    - clear_req → S_CLEAR, counter=0.
    - Else swap_req → S_SWAP.
    - clear_req has priority if coincident; the swap is then held pending and taken on return to S_IDLE.
  - S_CLEAR:
    - Each cycle without disp_req: write 0 at counter in the current bank, counter+1.
    - Display cycles stall the counter.
    - After writing address M*N-1 → S_IDLE.
    - clear_req while in S_CLEAR restarts the counter at 0.
  - S_SWAP:
    - Waits until no engine read is in flight (evo_rvalid pending=0).
    - Then flips bank, pulses swap_done for one cycle → S_IDLE.
    - An additional swap_req while in S_SWAP is ignored.
- busy=1 in S_CLEAR, S_SWAP, or while a swap is pending.
- swap_done and the bank flip occur on the same clock edge. The first access after the flip uses the new bank.
- rst mid-sweep or mid-swap: immediate return to reset values. A partial clear is left as-is; no swap occurs.

Test Plan:
- Reset, all req=0 → all outputs 0, bank=0, ram_we=0 for 10 cycles.
- disp_req and evo_req (read, addr 7) same cycle → ram_addr={0,7} for display, evo_gnt=0; next cycle evo_gnt=1; evo_rvalid the cycle after with RAM value at {0,7}.
- evo_req write addr 3 data 1 and edit_req (evo_active=0) held continuously → grants alternate engine, editor, engine…; engine write hits ram_addr={1,3}, editor write hits bank 0.
- clear_req with 5x5 grid, disp_req asserted on 3 sweep cycles → exactly 25 zero writes to bank 0 over 28 cycles; busy high throughout, low after the last write.
- Engine read granted, swap_req next cycle → swap_done waits until evo_rvalid has fired, then pulses once; bank=1; subsequent display read ram_addr MSB=1.
- edit_req with evo_active=1 → edit_gnt stays 0; grant occurs on the first cycle after evo_active falls. Address 25 on a 5x5 grid → granted, ram_we=0.
